c7bexcp_ctl: RTL
================

C7BEXCP_CTL -- requirements
Module: c7bexcp_ctl

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 2, number of cycles `ecl_kill_e` is held after a commit (1..7).
REQ-002 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-003 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port ext_intr  in  1  raw external interrupt HWI0, asynchronous to clk.
REQ-005 SHALL have port valid_e  in  1  instruction present in _e.
REQ-006 SHALL have port pc_e  in  32  PC of _e instruction.
REQ-007 SHALL have port except_e  in  1  _e instruction raised a synchronous exception (ALE/INE/ADEF).
REQ-008 SHALL have port exccode_e  in  6  ecode of that exception.
REQ-009 SHALL have port badv_e  in  32  faulting address of that exception.
REQ-010 SHALL have port ertn_e  in  1  _e instruction is ERTN.
REQ-011 SHALL have port csr_ecl_crmd_ie  in  1  global interrupt enable (CRMD.IE).
REQ-012 SHALL have port csr_ecl_timer_intr  in  1  pending timer interrupt.
REQ-013 SHALL have port csr_eentry  in  32  exception entry address.
REQ-014 SHALL have port csr_era  in  32  exception return address.
REQ-015 SHALL have port ext_intr_sync  out  1  synchronised HWI0 to CSR ESTAT.IS.
REQ-016 SHALL have port exu_ifu_except  out  1  one-cycle exception commit strobe (_w) to CSR.
REQ-017 SHALL have port ecl_csr_exccode_w  out  6  ecode for ESTAT.
REQ-018 SHALL have port ecl_csr_badv_w  out  32  value for BADV.
REQ-019 SHALL have port ifu_exu_pc_w  out  32  value for ERA.
REQ-020 SHALL have port ecl_csr_ertn_w  out  1  one-cycle ERTN commit strobe.
REQ-021 SHALL have port ecl_ifu_redirect  out  1  one-cycle fetch redirect.
REQ-022 SHALL have port ecl_ifu_redirect_pc  out  32  redirect target.
REQ-023 SHALL have port ecl_kill_e  out  1  kill the younger instruction in _e.

Function
REQ-024 SHALL treat `intr_req = csr_ecl_crmd_ie & (csr_ecl_timer_intr | ext_intr_sync)`, sampled combinationally in _e.
REQ-025 SHALL, in IDLE with `valid_e`, accept an event with priority interrupt > except_e > ertn_e; an ertn_e with except_e set SHALL be taken as the exception.
REQ-026 SHALL register the accepted event into _w with 1-cycle latency; the next cycle SHALL assert exactly one of exu_ifu_except or ecl_csr_ertn_w, together with ecl_ifu_redirect.
REQ-027 SHALL, for an interrupt, drive exccode 6'h0, badv 32'h0 and pc_w equal to pc_e of the interrupted instruction.
REQ-028 SHALL, for an exception, drive exccode_e, badv_e and pc_e as captured.
REQ-029 SHALL set redirect_pc to csr_eentry for an exception or interrupt, and to csr_era for ERTN, sampled in the _w cycle.
REQ-030 SHALL implement FSM IDLE -> COMMIT (1 cycle) -> FLUSH (FLUSH_CYC cycles, down-counter) -> IDLE.
REQ-031 SHALL assert ecl_kill_e during COMMIT and FLUSH; valid_e, except_e and ertn_e SHALL be ignored in those states.
REQ-032 SHALL hold the _w data outputs stable from COMMIT until the next event; strobes SHALL be 0 outside COMMIT.
REQ-033 SHALL not accept an interrupt when valid_e=0; an interrupt pending through FLUSH SHALL be taken on the first valid_e in IDLE.

Reset
REQ-034 SHALL, on resetn=0 at a clock edge, enter IDLE, clear the flush counter and synchroniser, and drive all outputs to 0.
REQ-035 SHALL, when reset is applied mid-COMMIT or mid-FLUSH, abort the sequence with no further strobe or redirect.

Configuration
REQ-036 SHALL, with macro C7B_EXT_INTR_SYNC_EN defined, pass ext_intr through a two-flop synchroniser (ext_intr_sync lags by 2 cycles).
REQ-037 SHALL, without C7B_EXT_INTR_SYNC_EN, drive ext_intr_sync = ext_intr combinationally; the source is then required to be synchronous to clk.

Verification
REQ-038 SHALL cover: except_e=1, exccode_e=6'h09, badv_e=32'h1003, pc_e=32'h1c00_0040 -> next cycle except=1, exccode=6'h09, badv=32'h1003, pc_w=32'h1c00_0040, redirect_pc=csr_eentry; kill_e high for 3 cycles.
REQ-039 SHALL cover: ertn_e=1, csr_era=32'h1c00_0044 -> ertn_w=1, except=0, redirect_pc=32'h1c00_0044.
REQ-040 SHALL cover: crmd_ie=1, timer_intr=1 and except_e=1 in the same cycle -> exccode=6'h0, badv=0; the exception is not reported.
REQ-041 SHALL cover: crmd_ie=0, ext_intr=1 -> no strobe; with the macro, ext_intr_sync rises 2 cycles after ext_intr.
REQ-042 SHALL cover: a second except_e arriving during FLUSH -> ignored; resetn=0 in FLUSH -> all outputs 0 and IDLE next cycle.

Source files
------------

// File: rtl/c7bexcp_ctl.sv
// ---------------------------------------------------------------------------
// c7bexcp_ctl -- exception / interrupt / ERTN commit controller.
//
// Accepts one event from the _e stage (interrupt > exception > ERTN),
// registers it into _w, and then walks IDLE -> COMMIT -> FLUSH -> IDLE.
// COMMIT lasts one cycle and emits the CSR commit strobe together with
// the fetch redirect. FLUSH lasts FLUSH_CYC cycles. ecl_kill_e is high
// throughout COMMIT and FLUSH.
//
// Build option:
//   C7B_EXT_INTR_SYNC_EN - when defined, ext_intr passes through a two-flop
//                          synchroniser. When undefined, ext_intr_sync is a
//                          direct feed-through and ext_intr must already be
//                          synchronous to clk.
//
// Reset is synchronous and active-low (resetn).
// ---------------------------------------------------------------------------
module c7bexcp_ctl #(
  parameter int FLUSH_CYC = 2              // legal range 1..7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ext_intr,
  input  logic        valid_e,
  input  logic [31:0] pc_e,
  input  logic        except_e,
  input  logic [5:0]  exccode_e,
  input  logic [31:0] badv_e,
  input  logic        ertn_e,
  input  logic        csr_ecl_crmd_ie,
  input  logic        csr_ecl_timer_intr,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        ext_intr_sync,
  output logic        exu_ifu_except,
  output logic [5:0]  ecl_csr_exccode_w,
  output logic [31:0] ecl_csr_badv_w,
  output logic [31:0] ifu_exu_pc_w,
  output logic        ecl_csr_ertn_w,
  output logic        ecl_ifu_redirect,
  output logic [31:0] ecl_ifu_redirect_pc,
  output logic        ecl_kill_e
);

  // Value loaded into the flush down-counter on entry to FLUSH; FLUSH
  // exits on the cycle the counter reads zero, giving FLUSH_CYC cycles.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        accept;
  logic        intr_req;

  // Captured _w event: ertn_q selects the ERTN strobe and the ERA target.
  logic        ertn_q;
  logic [5:0]  exccode_q;
  logic [31:0] badv_q;
  logic [31:0] pc_q;

  // -------------------------------------------------------------------------
  // External interrupt synchroniser (optional)
  // -------------------------------------------------------------------------
`ifdef C7B_EXT_INTR_SYNC_EN
  logic [1:0] ext_sync_q;

  // Two-flop synchroniser for the asynchronous HWI0 line.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ext_sync_q <= 2'b00;
    end else begin
      ext_sync_q <= {ext_sync_q[0], ext_intr};
    end
  end

  assign ext_intr_sync = ext_sync_q[1];
`else
  assign ext_intr_sync = ext_intr;
`endif

  // Interrupt request is evaluated combinationally in _e.
  assign intr_req = csr_ecl_crmd_ie & (csr_ecl_timer_intr | ext_intr_sync);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------

  // State and flush-counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state, counter and accept decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    accept      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Only a valid _e instruction can carry any event, interrupts
        // included; a pending interrupt waits for the next valid_e.
        if (valid_e && (intr_req || except_e || ertn_e)) begin
          accept  = 1'b1;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_LOAD;
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_cnt_d = 3'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // _w capture
  // -------------------------------------------------------------------------

  // Register the accepted event; the CSR-facing data is held until the
  // next exception or interrupt replaces it.
  always_ff @(posedge clk) begin
    // NOTE: the _w data registers are reset because they drive outputs
    // that must read zero out of reset.
    if (!resetn) begin
      ertn_q    <= 1'b0;
      exccode_q <= 6'h00;
      badv_q    <= 32'h0;
      pc_q      <= 32'h0;
    end else if (accept) begin
      if (intr_req) begin
        // Interrupt: ecode 0, no faulting address, return to the
        // interrupted instruction.
        ertn_q    <= 1'b0;
        exccode_q <= 6'h00;
        badv_q    <= 32'h0;
        pc_q      <= pc_e;
      end else if (except_e) begin
        // Synchronous exception, also wins over ERTN on the same slot.
        ertn_q    <= 1'b0;
        exccode_q <= exccode_e;
        badv_q    <= badv_e;
        pc_q      <= pc_e;
      end else begin
        // ERTN writes no ESTAT/BADV/ERA, so the data registers hold.
        ertn_q    <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic in_commit;
  assign in_commit = (state_q == ST_COMMIT);

  assign exu_ifu_except    = in_commit & ~ertn_q;
  assign ecl_csr_ertn_w    = in_commit &  ertn_q;
  assign ecl_ifu_redirect  = in_commit;
  assign ecl_kill_e        = (state_q != ST_IDLE);

  assign ecl_csr_exccode_w = exccode_q;
  assign ecl_csr_badv_w    = badv_q;
  assign ifu_exu_pc_w      = pc_q;

  // Redirect target is sampled from the CSRs in the _w cycle itself so
  // any CSR update landing at the same edge is honoured.
  assign ecl_ifu_redirect_pc = !in_commit ? 32'h0 :
                               ertn_q     ? csr_era : csr_eentry;

endmodule
